clz_seq: RTL and testbench

CLZ_SEQ -- requirements
Module: clz_seq

---
 rtl/clz_seq.sv | 120 ++++++++++++
 tb/tb_clz_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/clz_seq.sv
// Sequential count-leading-zeros / count-leading-ones unit.
// Scans the operand STEP_BITS bits per cycle from the MSB and reports the count with a one-cycle done pulse.
module clz_seq #(
  parameter int STEP_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_clo,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] STEP_INC = 6'(STEP_BITS);

  state_t               state_r, state_n;
  logic [31:0]          sreg_r, sreg_n;
  logic [5:0]           cnt_r, cnt_n;
  logic [5:0]           res_r, res_n;
  logic                 busy_r, done_r;
  logic [STEP_BITS-1:0] group_s;
  logic [5:0]           cnt_step_s;
  logic [5:0]           cnt_hit_s;

  // Leading-zero count of one scan group (only used when the group holds a 1).
  function automatic logic [5:0] lzc_group(input logic [STEP_BITS-1:0] g);
    logic [5:0] n;
    logic       found;
    n     = 6'd0;
    found = 1'b0;
    for (int i = STEP_BITS - 1; i >= 0; i--) begin
      if (!found && g[i]) begin
        found = 1'b1;
      end else if (!found) begin
        n = n + 6'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  assign group_s    = sreg_r[31 -: STEP_BITS];
  assign cnt_step_s = cnt_r + STEP_INC;
  assign cnt_hit_s  = cnt_r + lzc_group(group_s);

  // Next-state, datapath and result-capture logic.
  always_comb begin
    state_n = state_r;
    sreg_n  = sreg_r;
    cnt_n   = cnt_r;
    res_n   = res_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          // Leading ones become leading zeros after inversion.
          sreg_n  = is_clo ? ~data_in : data_in;
          cnt_n   = 6'd0;
          state_n = SCAN;
        end else begin
          state_n = IDLE;
        end
      end
      SCAN: begin
        if (|group_s) begin
          cnt_n   = cnt_hit_s;
          res_n   = cnt_hit_s;
          state_n = DONE;
        end else begin
          cnt_n  = cnt_step_s;
          sreg_n = sreg_r << STEP_BITS;
          if (cnt_step_s == 6'd32) begin
            res_n   = cnt_step_s;
            state_n = DONE;
          end else begin
            state_n = SCAN;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      sreg_r  <= 32'd0;
      cnt_r   <= 6'd0;
      res_r   <= 6'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      sreg_r  <= sreg_n;
      cnt_r   <= cnt_n;
      res_r   <= res_n;
      busy_r  <= (state_n != IDLE);
      done_r  <= (state_n == DONE);
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = {26'd0, res_r};

endmodule

// File: tb/tb_clz_seq.sv
// Self-checking bench for clz_seq: directed corner cases plus randomized operations
// checked cycle by cycle against a count/latency reference model.
module tb_clz_seq;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_clo;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  clz_seq #(.STEP_BITS(STEP)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .is_clo  (is_clo),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Count of leading zeros of the operand (after inversion for CLO).
  function automatic int ref_count(input logic [31:0] d, input logic clo);
    logic [31:0] v;
    int n;
    v = clo ? ~d : d;
    n = 0;
    while (n < 32 && v[31 - n] == 1'b0) n++;
    return n;
  endfunction

  function automatic int ref_cycles(input int n);
    int k;
    k = n / STEP + 1;
    if (k > 32 / STEP) k = 32 / STEP;
    return k;
  endfunction

  // Called at a negedge in an IDLE cycle; drives start in that cycle (cycle 0).
  // noise: 0 = quiet, 1 = random inputs while busy, 2 = all-ones start in cycle 2.
  task automatic run_op(input logic [31:0] d, input logic clo, input int noise);
    int n;
    int k;
    n = ref_count(d, clo);
    k = ref_cycles(n);
    check("idle_busy", {31'd0, busy}, 32'd0);
    start   = 1'b1;
    data_in = d;
    is_clo  = clo;
    for (int c = 1; c <= k + 1; c++) begin
      @(negedge clk);
      check("busy", {31'd0, busy}, 32'd1);
      check("done", {31'd0, done}, (c == k + 1) ? 32'd1 : 32'd0);
      check("result", result, (c == k + 1) ? 32'(n) : last_res);
      case (noise)
        1: begin
          start   = 1'($urandom);
          data_in = $urandom;
          is_clo  = 1'($urandom);
        end
        2: begin
          start   = (c == 2);
          data_in = 32'hFFFF_FFFF;
          is_clo  = 1'b0;
        end
        default: start = 1'b0;
      endcase
    end
    start    = 1'b0;
    last_res = 32'(n);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("result_hold", result, last_res);
  endtask

  initial begin
    logic [31:0] d;
    rst      = 1'b1;
    start    = 1'b1;
    is_clo   = 1'b0;
    data_in  = 32'h0000_0001;
    last_res = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;

    // Start accepted in the first cycle after reset release.
    run_op(32'h8000_0000, 1'b0, 0);
    run_op(32'h0000_0000, 1'b0, 0);
    run_op(32'hFFFF_0F00, 1'b1, 0);
    run_op(32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h0001_0000, 1'b0, 2);

    // Reset mid-operation aborts it with no done pulse.
    start   = 1'b1;
    data_in = 32'h0000_0000;
    is_clo  = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("abort_done", {31'd0, done}, 32'd0);
      start = 1'b0;
      if (c == 3) begin
        rst   = 1'b1;
        start = 1'b1;
      end
    end
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done2", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    rst      = 1'b0;
    last_res = 32'd0;
    run_op(32'h0000_0001, 1'b0, 0);

    // Back-to-back with start held high.
    start   = 1'b1;
    data_in = 32'h4000_0000;
    is_clo  = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("b2b_busy", {31'd0, busy}, (c == 3) ? 32'd0 : 32'd1);
      check("b2b_done", {31'd0, done}, (c == 2 || c == 5) ? 32'd1 : 32'd0);
      if (c == 2 || c == 5) check("b2b_result", result, 32'd1);
    end
    start    = 1'b0;
    last_res = 32'd1;
    @(negedge clk);
    check("b2b_idle", {31'd0, busy}, 32'd0);

    // Randomized operands with a spread of leading-bit counts.
    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      d = d >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) d = 32'd0;
      if ($urandom_range(0, 1) == 1) d = ~d;
      run_op(d, 1'($urandom), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
